spi_req_arbiter: RTL and testbench

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

---
 rtl/spi_req_arbiter_if.sv | 35 +++
 rtl/spi_req_arbiter.sv | 169 ++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if
//   Bundle of the requester handshake, the SPI core handshake and the
//   arbiter status outputs for spi_req_arbiter.
//   slave  modport : arbiter side (drives req_ready, spi_start, spi_data,
//                    grant_id, arb_busy, err_timeout)
//   master modport : environment side (drives req_valid, req_data,
//                    spi_busy, spi_done)
//   N_REQ / DATA_W must match the parameters of the connected arbiter.
interface spi_req_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    spi_start;
    logic [DATA_W-1:0]       spi_data;
    logic                    spi_busy;
    logic                    spi_done;
    logic [ID_W-1:0]         grant_id;
    logic                    arb_busy;
    logic                    err_timeout;

    modport slave (
        input  req_valid, req_data, spi_busy, spi_done,
        output req_ready, spi_start, spi_data, grant_id, arb_busy, err_timeout
    );

    modport master (
        output req_valid, req_data, spi_busy, spi_done,
        input  req_ready, spi_start, spi_data, grant_id, arb_busy, err_timeout
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter
//   Round-robin arbiter letting N_REQ requesters share one SPI transmitter.
//   One frame is in flight at a time: IDLE -> START -> WAIT -> GAP -> IDLE.
//
// Ports
//   clk_100 : system clock, rising edge
//   a_rst_n : asynchronous active-low reset; release synchronised internally
//   bus     : spi_req_arbiter_if.slave
//             req_valid/req_data/req_ready : requester handshake (one-hot ready)
//             spi_start/spi_data           : start pulse and latched word to core
//             spi_busy/spi_done            : core status
//             grant_id, arb_busy           : owner of current frame, not-IDLE
//             err_timeout                  : watchdog abort pulse
//
// Parameters
//   N_REQ (2..8), DATA_W, GAP_CYC (idle cycles after a frame, 0 allowed),
//   TIMEOUT_CYC (watchdog limit in WAIT cycles)
//
// Build option
//   SPI_ARB_TIMEOUT_EN : when defined, a watchdog aborts a WAIT that lasts
//   TIMEOUT_CYC cycles. When undefined, err_timeout is 0 and WAIT holds
//   until spi_done.
module spi_req_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 16,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                clk_100,
    input logic                a_rst_n,
    spi_req_arbiter_if.slave   bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    // Reset: assertion is immediate, release waits two clk_100 edges so
    // every flop leaves reset on the same clean edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [DATA_W-1:0] spi_data_q;
    logic [ID_W-1:0]   grant_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic              wd_expire;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    logic [N_REQ-1:0]  sel;
    logic              sel_any;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   ptr_nxt;
    logic [DATA_W-1:0] sel_data;
    int                idx;

    always_comb begin
        sel     = '0;
        sel_any = 1'b0;
        sel_id  = '0;
        ptr_nxt = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!sel_any && bus.req_valid[ID_W'(idx)]) begin
                sel_any            = 1'b1;
                sel[ID_W'(idx)]    = 1'b1;
                sel_id             = ID_W'(idx);
                ptr_nxt            = (idx == N_REQ - 1) ? '0 : ID_W'(idx + 1);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (sel[j]) sel_data = bus.req_data[j*DATA_W +: DATA_W];
        end
    end

    // FSM next state and combinational outputs
    logic [N_REQ-1:0] ready;
    logic             start;

    always_comb begin
        state_nxt = state;
        ready     = '0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                // no acceptance while the reset release is still in flight
                if (rst_n) begin
                    ready = sel;
                    if (sel_any) state_nxt = START;
                end
            end
            START: begin
                if (!bus.spi_busy) begin
                    start     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // a timeout is handled exactly like a completed frame
                if (bus.spi_done || wd_expire)
                    state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            spi_data_q <= '0;
            grant_q    <= '0;
            gap_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && sel_any) begin
                spi_data_q <= sel_data;
                grant_q    <= sel_id;
                rr_ptr     <= ptr_nxt;
            end
            if (state == GAP && state_nxt == GAP) gap_cnt <= gap_cnt + 1'b1;
            else                                  gap_cnt <= '0;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // wd_cnt holds k-1 in the k-th WAIT cycle, so the abort lands on
    // WAIT cycle TIMEOUT_CYC.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n)                               wd_cnt <= '0;
        else if (state == WAIT && state_nxt == WAIT) wd_cnt <= wd_cnt + 1'b1;
        else                                      wd_cnt <= '0;
    end

    assign wd_expire       = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    // a spi_done arriving on the limit cycle wins: no error reported
    assign bus.err_timeout = (state == WAIT) && wd_expire && !bus.spi_done;
`else
    assign wd_expire       = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.req_ready = ready;
    assign bus.spi_start = start;
    assign bus.spi_data  = spi_data_q;
    assign bus.grant_id  = grant_q;
    assign bus.arb_busy  = (state != IDLE);
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter
//   Table of single-frame vectors plus hand-written sequences for
//   round-robin fairness, busy back-pressure, mid-frame reset and the
//   watchdog. Expected frames are queued at acceptance and popped at
//   each spi_start.
module tb_spi_req_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    localparam int G = 4;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_req_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    spi_req_arbiter #(.N_REQ(N), .DATA_W(W), .GAP_CYC(G), .TIMEOUT_CYC(T)) dut (
        .clk_100 (clk),
        .a_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] valid;
        logic [W-1:0] data;
        int           busy;
        int           exp_id;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   id;
    } sb_t;

    vec_t vecs[6];
    sb_t  sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [W-1:0] d);
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = d + W'(i) * 16'h1111;
    endtask

    task automatic push(input logic [W-1:0] d, input int id);
        sb_t e;
        e.data = d + W'(id) * 16'h1111;
        e.id   = 2'(id);
        sb_q.push_back(e);
    endtask

    // call at a negedge where a start pulse is due
    task automatic expect_start();
        sb_t e;
        chk("spi_start", 32'(bus.spi_start), 32'd1);
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard: start with no queued frame");
        end else begin
            e = sb_q.pop_front();
            chk("spi_data", 32'(bus.spi_data), 32'(e.data));
            chk("grant_id", 32'(bus.grant_id), 32'(e.id));
        end
    endtask

    task automatic apply_vec(input vec_t v);
        @(posedge clk); #1;
        bus.req_valid = v.valid;
        fill(v.data);
        bus.spi_busy = (v.busy > 0);
        @(negedge clk);
        chk("req_ready", 32'(bus.req_ready), 32'(1 << v.exp_id));
        push(v.data, v.exp_id);
        @(posedge clk); #1;
        bus.req_valid = '0;
        for (int k = 0; k < v.busy; k++) begin
            @(negedge clk);
            chk("start_held", 32'(bus.spi_start), 32'd0);
            @(posedge clk); #1;
            if (k == v.busy - 1) bus.spi_busy = 1'b0;
        end
        @(negedge clk);
        expect_start();
        chk("ready_off", 32'(bus.req_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("data_stable", 32'(bus.spi_data), 32'(v.data + W'(v.exp_id) * 16'h1111));
        @(posedge clk); #1;
        bus.spi_done = 1'b1;
        @(posedge clk); #1;
        bus.spi_done = 1'b0;
        for (int g = 0; g < G; g++) begin
            @(negedge clk);
            chk("gap_busy", 32'(bus.arb_busy), 32'd1);
        end
        @(negedge clk);
        chk("idle_after_gap", 32'(bus.arb_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   cnt;
        int   bad;
        vec_t rv;

        vecs[0] = '{4'b0001, 16'hA5C3, 0,  0};
        vecs[1] = '{4'b1001, 16'h1234, 0,  3};
        vecs[2] = '{4'b0110, 16'h2468, 0,  1};
        vecs[3] = '{4'b0110, 16'h0F00, 0,  2};
        vecs[4] = '{4'b0011, 16'h7777, 0,  0};
        vecs[5] = '{4'b1000, 16'hBEEF, 10, 3};

        bus.req_valid = 4'hF;
        bus.spi_busy  = 1'b0;
        bus.spi_done  = 1'b0;
        fill(16'h0101);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",    32'(bus.req_ready),   32'd0);
        chk("rst_start",    32'(bus.spi_start),   32'd0);
        chk("rst_busy",     32'(bus.arb_busy),    32'd0);
        chk("rst_data",     32'(bus.spi_data),    32'd0);
        chk("rst_grant",    32'(bus.grant_id),    32'd0);
        chk("rst_timeout",  32'(bus.err_timeout), 32'd0);
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // table of single frames
        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // fairness: all valid continuously, rr_ptr starts at 0
        @(posedge clk); #1;
        bus.req_valid = 4'hF;
        fill(16'h3000);
        for (int f = 0; f < 5; f++) begin
            cnt = 0;
            @(negedge clk);
            while (bus.req_ready == '0 && cnt < 50) begin
                cnt++;
                @(negedge clk);
            end
            if (f > 0) chk("gap_len_ge4", 32'(cnt >= G), 32'd1);
            chk("rr_ready", 32'(bus.req_ready), 32'(1 << (f % N)));
            push(16'h3000, f % N);
            @(posedge clk);
            @(negedge clk);
            expect_start();
            repeat (19) @(posedge clk);
            #1 bus.spi_done = 1'b1;
            @(posedge clk); #1;
            bus.spi_done = 1'b0;
        end
        bus.req_valid = '0;
        repeat (G + 1) @(negedge clk);
        chk("rr_idle", 32'(bus.arb_busy), 32'd0);

        // reset three cycles into WAIT (rr_ptr is 1 here)
        @(posedge clk); #1;
        bus.req_valid = 4'b0100;
        fill(16'h5A00);
        @(negedge clk);
        chk("mr_ready", 32'(bus.req_ready), 32'b0100);
        push(16'h5A00, 2);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        expect_start();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        chk("mr_busy",    32'(bus.arb_busy),  32'd0);
        chk("mr_start",   32'(bus.spi_start), 32'd0);
        chk("mr_data",    32'(bus.spi_data),  32'd0);
        chk("mr_grant",   32'(bus.grant_id),  32'd0);
        chk("mr_ready",   32'(bus.req_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 bus.req_valid = '0;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.spi_start !== 1'b0 || bus.arb_busy !== 1'b0) bad++;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);
        // rr_ptr was cleared: from 0 the first of {1,3} is 1
        rv = '{4'b1010, 16'h0F0F, 0, 1};
        apply_vec(rv);

        // watchdog stimulus: spi_done never returns (rr_ptr is 2)
        @(posedge clk); #1;
        bus.req_valid = 4'b0001;
        fill(16'hC0DE);
        @(negedge clk);
        chk("wd_ready", 32'(bus.req_ready), 32'b0001);
        push(16'hC0DE, 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        expect_start();
`ifdef SPI_ARB_TIMEOUT_EN
        bad = 0;
        for (int c = 1; c < T; c++) begin
            @(negedge clk);
            if (bus.err_timeout !== 1'b0) bad++;
        end
        chk("wd_early", 32'(bad), 32'd0);
        @(negedge clk);
        chk("wd_pulse", 32'(bus.err_timeout), 32'd1);
        for (int g = 0; g < G; g++) begin
            @(negedge clk);
            chk("wd_gap", 32'({bus.arb_busy, bus.err_timeout}), 32'b10);
        end
        @(negedge clk);
        chk("wd_idle", 32'(bus.arb_busy), 32'd0);
`else
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus.err_timeout !== 1'b0 || bus.arb_busy !== 1'b1) bad++;
        end
        chk("wait_hold_1000", 32'(bad), 32'd0);
`endif
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
